// File: rtl/axist_sched_pkg.sv
// Shared types for the AXIST pattern-generator run sequencer: FSM states and
// generator mode-select encodings.
package axist_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    GEN,
    WAIT,
    NEXT,
    DONE
  } state_e;

  localparam logic [1:0] SEL_FIXED = 2'b00;
  localparam logic [1:0] SEL_RAND  = 2'b01;
  localparam logic [1:0] SEL_INCR  = 2'b10;
  localparam logic [1:0] SEL_NONE  = 2'b11;

endpackage

// File: rtl/axist_sched_mode_pick.sv
// Combinational picker: next enabled mode above cur_sel, or the lowest enabled
// mode with wrap=1 when nothing above remains (cur_sel=SEL_NONE yields the lowest).
module axist_sched_mode_pick
  import axist_sched_pkg::*;
(
  input  logic [2:0] mask,
  input  logic [1:0] cur_sel,
  output logic [1:0] nxt_sel,
  output logic       wrap
);

  logic [1:0] above;
  logic [1:0] lowest;
  logic       found;

  always_comb begin
    // NOTE: every output of this block gets a default before the loop, so no path can infer a latch.
    above  = SEL_NONE;
    lowest = SEL_NONE;
    found  = 1'b0;
    // Descending scan: the last hit wins, so each result ends up as the lowest qualifying bit.
    for (int i = 2; i >= 0; i--) begin
      if (mask[i]) begin
        lowest = 2'(i);
        if (i > int'(cur_sel)) begin
          above = 2'(i);
          found = 1'b1;
        end
      end
    end
    nxt_sel = found ? above : lowest;
    wrap    = !found;
  end

endmodule

// File: rtl/axi_st_patgen_sched.sv
// Run-sequencer for the AXIST simplex pattern generator: loops over enabled modes,
// arms the generator, counts its writes, and collects checker verdicts.
// Optional checker-wait watchdog enabled by defining AXIST_SCHED_TIMEOUT_EN.
module axi_st_patgen_sched
  import axist_sched_pkg::*;
#(
  parameter int LOOP_W = 8,
  parameter int TMO_W  = 16
) (
  input  logic              wr_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        mode_mask,
  input  logic [8:0]        burst_cnt,
  input  logic [LOOP_W-1:0] num_loops,
  input  logic [TMO_W-1:0]  tmo_limit,
  input  logic              patgen_data_wr,
  input  logic              chkr_done,
  input  logic              chkr_pass,
  output logic              patgen_en,
  output logic [1:0]        patgen_sel,
  output logic [8:0]        patgen_cnt,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_sel,
  output logic [11:0]       run_cnt
);

  state_e            state_q;
  logic [2:0]        mask_q;
  logic [LOOP_W-1:0] loops_q;
  logic [LOOP_W-1:0] loop_q;
  logic [8:0]        wr_cnt_q;
  logic              pend_q;
  logic              pend_pass_q;
  logic [1:0]        sel_q;
  logic [8:0]        cnt_q;
  logic              en_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [1:0]        fail_sel_q;
  logic [11:0]       run_cnt_q;

  logic [2:0]        pick_mask;
  logic [1:0]        pick_cur;
  logic [1:0]        pick_sel;
  logic              pick_wrap;
  logic [8:0]        wr_cnt_d;
  logic [LOOP_W-1:0] loop_d;
  logic [11:0]       run_cnt_d;
  logic              run_end;
  logic              run_ok;

  // In IDLE the picker sees the live mask with no current mode, giving the first run's mode.
  assign pick_mask = (state_q == IDLE) ? mode_mask : mask_q;
  assign pick_cur  = (state_q == IDLE) ? SEL_NONE  : sel_q;

  axist_sched_mode_pick u_pick (
    .mask    (pick_mask),
    .cur_sel (pick_cur),
    .nxt_sel (pick_sel),
    .wrap    (pick_wrap)
  );

  assign wr_cnt_d  = wr_cnt_q + 9'd1;
  assign loop_d    = loop_q + LOOP_W'(1);
  assign run_cnt_d = (run_cnt_q == 12'hFFF) ? run_cnt_q : run_cnt_q + 12'd1;

`ifdef AXIST_SCHED_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_hit;

  assign tmo_hit = ({1'b0, tmo_q} + (TMO_W+1)'(1)) >= {1'b0, tmo_limit};
  assign run_end = pend_q | chkr_done | tmo_hit;
  assign run_ok  = pend_q ? pend_pass_q : (chkr_done & chkr_pass);

  always_ff @(posedge wr_clk) begin
    if (!rst_n || state_q != WAIT) begin
      tmo_q <= '0;
    end else if (!run_end) begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end
`else
  logic tmo_unused;

  assign tmo_unused = ^tmo_limit;
  assign run_end    = pend_q | chkr_done;
  assign run_ok     = pend_q ? pend_pass_q : chkr_pass;
`endif

  always_ff @(posedge wr_clk) begin
    if (!rst_n) begin
      // NOTE: the latched run context is reset too, so a mid-run reset cannot leak stale state.
      state_q     <= IDLE;
      mask_q      <= '0;
      loops_q     <= '0;
      loop_q      <= '0;
      wr_cnt_q    <= '0;
      pend_q      <= 1'b0;
      pend_pass_q <= 1'b0;
      sel_q       <= SEL_FIXED;
      cnt_q       <= '0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_sel_q  <= SEL_NONE;
      run_cnt_q   <= '0;
    end else begin
      en_q   <= 1'b0;
      done_q <= 1'b0;
      if (abort && state_q != IDLE) begin
        state_q    <= IDLE;
        busy_q     <= 1'b0;
        done_q     <= 1'b1;
        pass_q     <= 1'b0;
        fail_sel_q <= SEL_NONE;
        pend_q     <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              mask_q     <= mode_mask;
              cnt_q      <= burst_cnt;
              loops_q    <= (num_loops == '0) ? LOOP_W'(1) : num_loops;
              loop_q     <= '0;
              run_cnt_q  <= '0;
              fail_sel_q <= SEL_NONE;
              busy_q     <= 1'b1;
              pend_q     <= 1'b0;
              if (mode_mask == 3'b000) begin
                pass_q  <= 1'b0;
                state_q <= DONE;
              end else begin
                pass_q  <= 1'b1;
                sel_q   <= pick_sel;
                state_q <= ARM;
              end
            end
          end
          ARM: begin
            en_q     <= 1'b1;
            wr_cnt_q <= '0;
            pend_q   <= 1'b0;
            state_q  <= (cnt_q == 9'd0) ? WAIT : GEN;
          end
          GEN: begin
            if (patgen_data_wr) begin
              wr_cnt_q <= wr_cnt_d;
              if (wr_cnt_d == cnt_q) begin
                state_q     <= WAIT;
                pend_q      <= chkr_done;
                pend_pass_q <= chkr_pass;
              end
            end
          end
          WAIT: begin
            if (run_end) begin
              run_cnt_q <= run_cnt_d;
              pend_q    <= 1'b0;
              if (!run_ok) begin
                pass_q <= 1'b0;
                if (fail_sel_q == SEL_NONE) fail_sel_q <= sel_q;
              end
              state_q <= NEXT;
            end
          end
          NEXT: begin
            if (pick_wrap && loop_d == loops_q) begin
              loop_q  <= loop_d;
              state_q <= DONE;
            end else begin
              if (pick_wrap) loop_q <= loop_d;
              sel_q   <= pick_sel;
              state_q <= ARM;
            end
          end
          DONE: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign patgen_en  = en_q;
  assign patgen_sel = sel_q;
  assign patgen_cnt = cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_sel   = fail_sel_q;
  assign run_cnt    = run_cnt_q;

endmodule
